// File: rtl/voice_sequencer.sv
// Per-sample voice scheduler: walks enabled voices, sums samples, emits mix.
// Optional SYNTH_VOICE_MUTE_EN adds a mute mask applied at frame snapshot.
module voice_sequencer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          sample_now,
  input  logic [NUM_VOICES-1:0]         voice_en,
`ifdef SYNTH_VOICE_MUTE_EN
  input  logic [NUM_VOICES-1:0]         mute,
`endif
  input  logic                          ovr_clr,
  output logic                          vreq,
  output logic [$clog2(NUM_VOICES)-1:0] vsel,
  input  logic                          vack,
  input  logic [SAMPLE_W-1:0]           vdata,
  output logic [SAMPLE_W-1:0]           mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int AW = SAMPLE_W + IW;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REQ,
    DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [IW-1:0]           idx;
  logic [AW-1:0]           acc;
  logic [NUM_VOICES-1:0]   en_q;
  logic [NUM_VOICES-1:0]   en_snap;
  logic                    last;
  logic                    cur_en;

`ifdef SYNTH_VOICE_MUTE_EN
  assign en_snap = voice_en & ~mute;
`else
  assign en_snap = voice_en;
`endif

  assign last   = (idx == LAST);
  assign cur_en = en_q[idx];
  assign vreq   = (state_q == REQ);
  assign busy   = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sample_now) state_d = SCAN;
      SCAN: begin
        if (cur_en)    state_d = REQ;
        else if (last) state_d = DONE;
      end
      REQ: begin
        if (vack) state_d = last ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: snapshot, voice index, accumulator, mix output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx       <= '0;
      acc       <= '0;
      en_q      <= '0;
      vsel      <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (sample_now) begin
            en_q <= en_snap;
            acc  <= '0;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (cur_en)     vsel <= idx;
          else if (!last) idx  <= idx + 1'b1;
        end
        REQ: begin
          if (vack) begin
            acc <= acc + AW'(vdata);
            if (!last) idx <= idx + 1'b1;
          end
        end
        DONE:    mix_out <= SAMPLE_W'(acc >> IW);
        default: ;
      endcase
    end
  end

  // Sticky overrun: a dropped tick beats a simultaneous clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                  overrun <= 1'b0;
    else if (sample_now && busy) overrun <= 1'b1;
    else if (ovr_clr)            overrun <= 1'b0;
  end

endmodule

// File: doc/voice_sequencer.md
# voice_sequencer

Per-sample scheduler for the synthesizer's shared voice datapath. On every `sample_now` tick from the sample-rate clock divider (one pulse per 64 `clk` cycles), the block:
- walks the enabled voices in index order;
- time-multiplexes the single waveform/voice unit between them over a request/acknowledge handshake;
- accumulates the returned samples;
- publishes one averaged mix sample to the output stage.

It also flags ticks that arrive before the previous frame has finished.

## Interface
Parameters:
- `NUM_VOICES`, default 4: number of voices. Must be a power of two, ≥2.
- `SAMPLE_W`, default 8: unsigned width of voice samples and of the mix sample.

Ports:
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `sample_now`  in  1  single-cycle frame tick from the clock divider.
- `voice_en`  in  NUM_VOICES  per-voice enable (note-on). Bit i enables voice i.
- `ovr_clr`  in  1  synchronous clear of `overrun`.
- `vreq`  out  1  request to the shared voice datapath.
- `vsel`  out  $clog2(NUM_VOICES)  index of the voice being requested.
- `vack`  in  1  datapath acknowledge. `vdata` is valid in the same cycle.
- `vdata`  in  SAMPLE_W  unsigned sample for voice `vsel`.
- `mix_out`  out  SAMPLE_W  registered mix sample. Held between frames.
- `mix_valid`  out  1  one-cycle pulse marking a new `mix_out`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `overrun`  out  1  sticky flag: a tick was dropped.

## Operation
- States: IDLE, SCAN, REQ, DONE.
- **IDLE**
  - When `sample_now`=1: snapshot `voice_en` into `en_q`, clear the accumulator, set `idx`=0, go to SCAN.
  - `en_q` is frozen for the whole frame; changes to `voice_en` mid-frame have no effect.
- **SCAN** (exactly 1 cycle, evaluates `en_q[idx]`)
  - Enabled voice: go to REQ.
  - Disabled voice, `idx`<N-1: increment `idx`, stay in SCAN.
  - Disabled voice, `idx`=N-1: go to DONE.
- **REQ**
  - `vreq`=1 and `vsel`=`idx`, both held stable until `vack`.
  - On `vack`: `acc += vdata`.
    - `idx`<N-1: increment `idx`, go to SCAN.
    - `idx`=N-1: go to DONE.
- **DONE** (1 cycle)
  - At the exiting edge: `mix_out <= acc >> log2(NUM_VOICES)`, `mix_valid <= 1`, go to IDLE.
- Accumulator width is SAMPLE_W+log2(NUM_VOICES), so it never overflows.
  - The output is the sum divided by NUM_VOICES, not by the enabled count. Disabled voices contribute 0.
- `vreq` is 0 outside REQ. `vsel` holds its last value outside REQ.
- `vack` while `vreq`=0 is ignored, and `vdata` is not sampled.
- `sample_now` while state ≠ IDLE (including DONE): the tick is dropped, `overrun` is set, and the current frame continues undisturbed.
- `overrun` stays high until `ovr_clr`. If a set and `ovr_clr` occur in the same cycle, the set wins.
- Reset values: state IDLE, `idx` 0, acc 0, `vreq` 0, `vsel` 0, `mix_out` 0, `mix_valid` 0, `busy` 0, `overrun` 0.
- Reset asserted mid-frame aborts the frame immediately: no `mix_valid`, and `mix_out` returns to 0.

## Timing
- Tick accepted in cycle 0 → SCAN in cycle 1.
- Each enabled voice costs 1 SCAN cycle plus k REQ cycles, where k ≥ 1 and the REQ cycles include the `vack` cycle.
- Each disabled voice costs 1 SCAN cycle.
- DONE costs 1 cycle. `mix_valid` is high in the first IDLE cycle after DONE.
- N=4, all enabled, `vack` tied high: `vreq` high in cycles 2, 4, 6, 8; DONE in cycle 9; `mix_valid` in cycle 10.
- N=4, none enabled: DONE in cycle 5, `mix_valid` in cycle 6.
- A tick arriving in the same cycle that `mix_valid` is high is in IDLE and is accepted.
- The frame fits inside the 64-cycle tick period if the total `vack` wait is ≤ 53 cycles (N=4, all enabled).

## Configuration
- Macro `SYNTH_VOICE_MUTE_EN`.
- Defined:
  - Adds port `mute`  in  NUM_VOICES.
  - Snapshot becomes `en_q = voice_en & ~mute`, so a muted voice is skipped exactly like a disabled one.
- Undefined:
  - No `mute` port.
  - `en_q = voice_en`.

## Test plan
- Reset mid-REQ with `vreq`=1 → all outputs go to their reset values in the same cycle. No `mix_valid` follows; the next tick starts a clean frame.
- N=4, `voice_en`=4'b1111, `vack` tied 1, `vdata`=40,80,120,200 for voices 0–3 → `vreq` in cycles 2, 4, 6, 8; `mix_valid` in cycle 10; `mix_out`=110 (440>>2).
- `voice_en`=4'b0101, `vack` delayed 3 cycles per request, `vdata`=255 → only `vsel`=0 then 2 are requested, `vsel` held stable while waiting, `mix_out`=127 (510>>2).
- `voice_en`=0 → no `vreq`; `mix_valid` in cycle 6 with `mix_out`=0. Toggling `voice_en` mid-frame does not change `mix_out`.
- Second `sample_now` in cycle 5 of a frame → `overrun`=1 and the frame completes normally. Then `ovr_clr` and a new overrun tick in the same cycle → `overrun` stays 1.
- With `SYNTH_VOICE_MUTE_EN` defined, `voice_en`=4'b1111, `mute`=4'b0010 → voice 1 is never requested; `mix_out`=(v0+v2+v3)>>2.
